// File: rtl/comparador_pkg.sv
// comparador_pkg: shared width default and compare-result encoding for the comparator.
package comparador_pkg;
    localparam int COMPARADOR_DEF_WIDTH = 8;
    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_res_t;
endpackage

// File: rtl/comparador_core.sv
// comparador_core: combinational MSB-first magnitude compare of A and B.
// Two's-complement operands when COMPARADOR_SIGNED_EN is defined, unsigned otherwise.
module comparador_core
    import comparador_pkg::*;
#(
    parameter int WIDTH = COMPARADOR_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output cmp_res_t         res
);
`ifdef COMPARADOR_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif
    // Higher bits overwrite lower ones, so the most significant differing bit decides;
    // in signed mode a set sign bit means the smaller value.
    always_comb begin
        res = CMP_EQ;
        for (int i = 0; i < WIDTH; i++)
            if (A[i] != B[i])
                res = (A[i] ^ (SGN && i == WIDTH-1)) ? CMP_GT : CMP_LT;
    end
endmodule

// File: rtl/comparador_secuencial.sv
// comparador_secuencial: registered greater-than flag q = (A > B), one-cycle latency.
// COMPARADOR_SIGNED_EN selects two's-complement operands.
module comparador_secuencial
    import comparador_pkg::*;
#(
    parameter int WIDTH = COMPARADOR_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             q
);
    cmp_res_t res;
    comparador_core #(.WIDTH(WIDTH)) u_core (.A(A), .B(B), .res(res));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else        q <= (res == CMP_GT);
endmodule

// File: tb/tb_comparador_secuencial.sv
// tb_comparador_secuencial: scoreboard bench for the registered comparator.
module tb_comparador_secuencial;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] a, b;
    logic q;
    int checks = 0;
    int failures = 0;
    bit exp_q[$];

    always #10 clk = ~clk;

    comparador_secuencial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .A(a), .B(b), .q(q));

    function automatic bit model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef COMPARADOR_SIGNED_EN
        return $signed(x) > $signed(y);
`else
        return x > y;
`endif
    endfunction

    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a = 8'd18;
        b = 8'd10;
        #1;
        checks++;
        if (q !== 1'b0) begin failures++; $display("FAIL reset_now q=%b expected 0", q); end
        repeat (3) begin
            @(posedge clk);
            #2;
            checks++;
            if (q !== 1'b0) begin failures++; $display("FAIL reset_hold q=%b expected 0", q); end
        end
    endtask

    task automatic test_compare;
        logic [W-1:0] pa[3] = '{8'd18, 8'd10, 8'd36};
        logic [W-1:0] pb[3] = '{8'd10, 8'd18, 8'd36};
        bit e;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(pa[i], pb[i]);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin failures++; $display("FAIL compare A=%0d B=%0d q=%b expected %b", pa[i], pb[i], q, e); end
        end
    endtask

    task automatic test_extremes;
        logic [W-1:0] pa[4] = '{8'hFF, 8'h00, 8'h80, 8'h7F};
        logic [W-1:0] pb[4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
        bit e;
        for (int i = 0; i < 4; i++) begin
            apply(pa[i], pb[i]);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin failures++; $display("FAIL extremes A=%h B=%h q=%b expected %b", pa[i], pb[i], q, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] x, y;
        bit e;
        for (int i = 0; i < 30; i++) begin
            x = W'($urandom_range(0, 255));
            y = (i % 5 == 0) ? x : W'($urandom_range(0, 255));
            apply(x, y);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin failures++; $display("FAIL back_to_back A=%h B=%h q=%b expected %b", x, y, q, e); end
            if (i % 7 == 0) begin
                apply(x, y);
                e = exp_q.pop_front();
                checks++;
                if (q !== e) begin failures++; $display("FAIL stable A=%h B=%h q=%b expected %b", x, y, q, e); end
            end
        end
    endtask

    task automatic test_mid_reset;
        bit e;
        apply(8'd18, 8'd10);
        e = exp_q.pop_front();
        checks++;
        if (q !== 1'b1 || e !== 1'b1) begin failures++; $display("FAIL mid_reset_pre q=%b model=%b expected 1", q, e); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 1'b0) begin failures++; $display("FAIL mid_reset_async q=%b expected 0", q); end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (q !== 1'b0) begin failures++; $display("FAIL mid_reset_release q=%b expected 0", q); end
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (q !== e || e !== 1'b1) begin failures++; $display("FAIL mid_reset_reload q=%b expected %b", q, e); end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_extremes();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left size=%0d expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
